// File: rtl/column_gather_if.sv
// column_gather_if: request/response and memory-read signals of column_gather.
//   start, col, abort   request side (col holds LANES packed CW-bit indices)
//   busy, done, err     status; done/err are one-cycle pulses
//   pipe                gathered result, LANES packed DEPTH-bit vectors
//   mem_rd, mem_addr    read strobe/address towards a synchronous word memory
//   mem_rdata           read data, valid one cycle after the memory samples
// The slave modport is the gatherer's view; master is the requester/memory view.
interface column_gather_if #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64,
  parameter int LANES = 1
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                   start;
  logic [LANES*CW-1:0]    col;
  logic                   abort;
  logic                   mem_rd;
  logic [AW-1:0]          mem_addr;
  logic [WIDTH-1:0]       mem_rdata;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [LANES*DEPTH-1:0] pipe;

  modport master (
    output start, col, abort, mem_rdata,
    input  mem_rd, mem_addr, busy, done, err, pipe
  );

  modport slave (
    input  start, col, abort, mem_rdata,
    output mem_rd, mem_addr, busy, done, err, pipe
  );
endinterface

// File: rtl/column_gather.sv
// column_gather: reads DEPTH words from a latency-1 synchronous memory and, for
// each of LANES lanes, gathers one bit column into a DEPTH-bit vector
// (pipe lane l bit n = selected bit of word n).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  column_gather_if.slave (start/col/abort in, busy/done/err/pipe out,
//        mem_rd/mem_addr out, mem_rdata in)
// Results are assembled in a shadow register and copied to pipe only when the
// whole operation completes, so pipe never shows partial data.
module column_gather #(
  parameter int WIDTH     = 25,
  parameter int DEPTH     = 64,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  column_gather_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] TOP_BIT   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rd_q, rd_d;      // word requested last cycle is on mem_rdata
  logic [AW-1:0]          idx_q;           // address that word came from
  logic                   latch_cols;
  logic                   load_pipe;
  logic                   cols_ok;
  logic [CW-1:0]          col_l;
  logic [CW-1:0]          sel_d [LANES];
  logic [CW-1:0]          sel_q [LANES];
  logic [LANES*DEPTH-1:0] shadow_q, shadow_d;
  logic [LANES*DEPTH-1:0] pipe_q;

  // Validate the requested columns and translate them into bit positions.
  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    cols_ok = 1'b1;
    col_l   = '0;
    for (int l = 0; l < LANES; l++) begin
      col_l = bus.col[l*CW +: CW];
      if (int'(col_l) >= WIDTH) cols_ok = 1'b0;
      sel_d[l] = MSB_FIRST ? (TOP_BIT - col_l) : col_l;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_d       = mem_rd_q;
    latch_cols = 1'b0;
    load_pipe  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort beats start: a simultaneous request is simply dropped
        if (bus.start && !bus.abort) begin
          if (cols_ok) begin
            latch_cols = 1'b1;
            state_d    = FETCH;
            busy_d     = 1'b1;
            mem_rd_d   = 1'b1;
            addr_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      FETCH: begin
        if (bus.abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          mem_rd_d = 1'b0;
          rd_d     = 1'b0;
          addr_d   = '0;
        end else if (addr_q == LAST_ADDR) begin
          // last address is being sampled now; its data returns during DRAIN
          mem_rd_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      DRAIN: begin
        if (bus.abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          mem_rd_d = 1'b0;
          rd_d     = 1'b0;
          addr_d   = '0;
        end else begin
          load_pipe = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
          addr_d    = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        mem_rd_d = 1'b0;
        rd_d     = 1'b0;
        addr_d   = '0;
      end
    endcase
  end

  // Merge the returning word into the shadow. pipe is loaded from shadow_d so
  // the final word, arriving on the done edge, is included.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_q) begin
      for (int l = 0; l < LANES; l++) begin
        shadow_d[l*DEPTH + int'(idx_q)] = bus.mem_rdata[sel_q[l]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_rd_q <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= mem_rd_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      idx_q    <= addr_q;
      shadow_q <= shadow_d;
      if (load_pipe) pipe_q <= shadow_d;
    end
  end

  // NOTE: the per-lane select array is a handful of config flops, so it is
  // reset like any other register; large storage arrays would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) sel_q[l] <= '0;
    end else if (latch_cols) begin
      for (int l = 0; l < LANES; l++) sel_q[l] <= sel_d[l];
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.pipe     = pipe_q;
endmodule

// File: tb/tb_column_gather.sv
// tb_column_gather: directed bench for column_gather with a scoreboard.
// Three instances share one word memory image:
//   a: LANES=1, MSB_FIRST=1   b: LANES=1, MSB_FIRST=0   c: LANES=2, MSB_FIRST=1
// Stimulus pushes the expected done/err response into a per-instance queue;
// per-instance monitors pop and compare whenever done or err is presented.
module tb_column_gather;
  localparam int WIDTH = 25;
  localparam int DEPTH = 64;
  localparam logic [127:0] P55  = 128'h5555_5555_5555_5555;
  localparam logic [127:0] ONES = {128{1'b1}};

  typedef struct {
    bit           is_err;
    logic [127:0] pipe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  column_gather_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(1)) if_a ();
  column_gather_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(1)) if_b ();
  column_gather_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(2)) if_c ();

  column_gather #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(1), .MSB_FIRST(1'b1))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  column_gather #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(1), .MSB_FIRST(1'b0))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  column_gather #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(2), .MSB_FIRST(1'b1))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // Shared memory image with one latency-1 read port per instance.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (if_a.mem_rd) if_a.mem_rdata <= mem[if_a.mem_addr];
  always @(posedge clk) if (if_b.mem_rd) if_b.mem_rdata <= mem[if_b.mem_addr];
  always @(posedge clk) if (if_c.mem_rd) if_c.mem_rdata <= mem[if_c.mem_addr];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   done_a = 0;
  int   done_b = 0;
  int   done_c = 0;
  int   rd_cnt_a = 0;
  int   busy_cnt_a = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- accessors over the three instances ----------------
  task automatic drive(input int w, input logic st, input logic [9:0] col, input logic ab);
    case (w)
      0: begin if_a.start = st; if_a.col = col[4:0]; if_a.abort = ab; end
      1: begin if_b.start = st; if_b.col = col[4:0]; if_b.abort = ab; end
      default: begin if_c.start = st; if_c.col = col; if_c.abort = ab; end
    endcase
  endtask

  function automatic logic [127:0] get_pipe(input int w);
    case (w)
      0: return 128'(if_a.pipe);
      1: return 128'(if_b.pipe);
      default: return if_c.pipe;
    endcase
  endfunction

  function automatic logic [4:0] get_flags(input int w); // {busy, mem_rd, done, err, |addr}
    case (w)
      0: return {if_a.busy, if_a.mem_rd, if_a.done, if_a.err, |if_a.mem_addr};
      1: return {if_b.busy, if_b.mem_rd, if_b.done, if_b.err, |if_b.mem_addr};
      default: return {if_c.busy, if_c.mem_rd, if_c.done, if_c.err, |if_c.mem_addr};
    endcase
  endfunction

  task automatic push(input int w, input bit is_err, input logic [127:0] pipe);
    exp_t e;
    e.is_err = is_err;
    e.pipe   = pipe;
    case (w)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic sb_compare(input string tag, input exp_t e, input bit got_err, input logic [127:0] got_pipe);
    check({tag, "_kind_err"}, 128'(got_err), 128'(e.is_err));
    check({tag, "_pipe"}, got_pipe, e.pipe);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt_a   = 0;
      busy_cnt_a = 0;
    end else begin
      if (if_a.mem_rd) begin
        check("a_addr_order", 128'(if_a.mem_addr), 128'(rd_cnt_a));
        rd_cnt_a++;
      end
      if (if_a.busy) busy_cnt_a++;
      if (if_a.done || if_a.err) begin
        if (if_a.done) done_a++;
        if (q_a.size() == 0) check("a_unexpected_event", 128'({if_a.done, if_a.err}), 128'(0));
        else sb_compare("a", q_a.pop_front(), if_a.err, 128'(if_a.pipe));
        if (if_a.done) begin
          check("a_mem_rd_cycles", 128'(rd_cnt_a), 128'(DEPTH));
          check("a_busy_cycles", 128'(busy_cnt_a), 128'(DEPTH + 1));
        end
      end
      if (!if_a.busy) begin
        rd_cnt_a   = 0;
        busy_cnt_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (if_b.done || if_b.err)) begin
      if (if_b.done) done_b++;
      if (q_b.size() == 0) check("b_unexpected_event", 128'({if_b.done, if_b.err}), 128'(0));
      else sb_compare("b", q_b.pop_front(), if_b.err, 128'(if_b.pipe));
    end
  end

  always @(negedge clk) begin
    if (!rst && (if_c.done || if_c.err)) begin
      if (if_c.done) done_c++;
      if (q_c.size() == 0) check("c_unexpected_event", 128'({if_c.done, if_c.err}), 128'(0));
      else sb_compare("c", q_c.pop_front(), if_c.err, if_c.pipe);
    end
  end

  // ---------------- stimulus ----------------
  // One full operation; optional second start pulse at cycle restart_at.
  // done must appear at the 66th falling edge after start is sampled (E0+65).
  task automatic run(input int w, input logic [9:0] col, input logic [127:0] exp,
                     input int restart_at, input string name);
    int   k;
    logic [4:0] f;
    k = 0;
    push(w, 1'b0, exp);
    @(negedge clk);
    drive(w, 1'b1, col, 1'b0);
    do begin
      @(negedge clk);
      k++;
      drive(w, (k == restart_at), col, 1'b0);
      f = get_flags(w);
    end while (!f[2] && k < 200);
    check({name, "_done_latency"}, 128'(k), 128'(DEPTH + 2));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]   f;
    logic [127:0] prev;
    int           seen;
    int           d0;

    for (int w = 0; w < 3; w++) drive(w, 1'b0, 10'd0, 1'b0);
    for (int n = 0; n < DEPTH; n++) mem[n] = (n % 2 == 0) ? 25'h1000000 : 25'h0;
    repeat (3) @(negedge clk);

    // reset state of every instance
    for (int w = 0; w < 3; w++) begin
      check("reset_flags", 128'(get_flags(w)), 128'(0));
      check("reset_pipe", get_pipe(w), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // MSB-first col 0 picks bit 24 -> even words set
    run(0, 10'd0, P55, 0, "a_col0");
    // LSB-first col 24 also picks bit 24
    run(1, 10'd24, P55, 0, "b_col24");
    // LSB-first col 0 picks bit 0 -> nothing set
    run(1, 10'd0, 128'(0), 0, "b_col0");

    // out-of-range column: err next cycle, no access, pipe kept
    push(0, 1'b1, P55);
    drive(0, 1'b1, 10'd25, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 10'd0, 1'b0);
    f = get_flags(0);
    check("a_err_pulse", 128'(f[1]), 128'(1));
    seen = 0;
    repeat (5) begin
      f = get_flags(0);
      if (f[4] || f[3]) seen++;
      @(negedge clk);
    end
    check("a_err_no_busy_no_rd", 128'(seen), 128'(0));

    // abort together with start in IDLE: nothing starts, no err
    drive(0, 1'b1, 10'd0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 10'd0, 1'b0);
    f = get_flags(0);
    check("a_abort_start_idle", 128'(f), 128'(0));
    @(negedge clk);

    // abort at cycle 30 of a run
    d0 = done_a;
    drive(0, 1'b1, 10'd24, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 10'd24, 1'b0);
    repeat (29) @(negedge clk);
    drive(0, 1'b0, 10'd24, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 10'd24, 1'b0);
    f = get_flags(0);
    check("a_abort_busy_rd", 128'(f[4:3]), 128'(0));
    repeat (70) @(negedge clk);
    check("a_abort_no_done", 128'(done_a), 128'(d0));
    check("a_abort_pipe_kept", get_pipe(0), P55);

    // fresh run after abort, MSB-first col 24 picks bit 0
    run(0, 10'd24, 128'(0), 0, "a_col24");

    // two lanes, second start pulse while busy is ignored
    for (int n = 0; n < DEPTH; n++) mem[n] = 25'h1800000;
    d0 = done_c;
    run(2, {5'd1, 5'd0}, ONES, 10, "c_two_lanes");
    repeat (10) @(negedge clk);
    check("c_single_done", 128'(done_c - d0), 128'(1));

    // async reset in the middle of FETCH
    for (int n = 0; n < DEPTH; n++) mem[n] = (n % 2 == 0) ? 25'h1000000 : 25'h0;
    run(0, 10'd0, P55, 0, "a_rerun");
    prev = get_pipe(0);
    drive(0, 1'b1, 10'd0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 10'd0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("a_async_rst_flags", 128'(get_flags(0)), 128'(0));
    check("a_async_rst_pipe", get_pipe(0), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("a_pipe_before_reset_was_set", prev, P55);
    run(0, 10'd0, P55, 0, "a_after_reset");

    repeat (5) @(negedge clk);
    check("a_queue_empty", 128'(q_a.size()), 128'(0));
    check("b_queue_empty", 128'(q_b.size()), 128'(0));
    check("c_queue_empty", 128'(q_c.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
